// File: rtl/shared_debounce_ctrl_if.sv
// Debounce controller bus: raw switch levels in, clean levels/pulses out.
// master drives sw_in; slave (the controller) drives the rest.
interface shared_debounce_ctrl_if #(
  parameter int NSW = 4
);
  logic [NSW-1:0] sw_in;
  logic [NSW-1:0] sw_out;
  logic [NSW-1:0] sw_rise;
  logic [NSW-1:0] grant;
  logic           busy;
`ifdef SHARED_DEBOUNCE_FALL_EN
  logic [NSW-1:0] sw_fall;

  modport master (
    output sw_in,
    input  sw_out, sw_rise, sw_fall, grant, busy
  );
  modport slave (
    input  sw_in,
    output sw_out, sw_rise, sw_fall, grant, busy
  );
`else
  modport master (
    output sw_in,
    input  sw_out, sw_rise, grant, busy
  );
  modport slave (
    input  sw_in,
    output sw_out, sw_rise, grant, busy
  );
`endif
endinterface

// File: rtl/shared_debounce_ctrl.sv
// NSW-channel debouncer sharing one hold timer via a round-robin arbiter.
// Ports: clk, rst (async, active-high); bus.slave carries sw_in in and
// sw_out/sw_rise/grant/busy out. SHARED_DEBOUNCE_FALL_EN adds sw_fall.
module shared_debounce_ctrl #(
  parameter int NSW   = 4,
  parameter int TBITS = 16
) (
  input logic                   clk,
  input logic                   rst,
  shared_debounce_ctrl_if.slave bus
);
  localparam int PW = (NSW > 1) ? $clog2(NSW) : 1;
  localparam int CW = TBITS - 1;

  typedef enum logic {IDLE, HOLD} state_t;

  state_t         state, state_n;
  logic [NSW-1:0] out_q, out_n, out_d;
  logic [NSW-1:0] grant_q, grant_n;
  logic [NSW-1:0] rise_q;
  logic [NSW-1:0] req;
  logic [CW-1:0]  cnt, cnt_n;
  logic [PW-1:0]  ptr, ptr_n;
  logic [PW-1:0]  win, idx;
  logic           found, expire;
`ifdef SHARED_DEBOUNCE_FALL_EN
  logic [NSW-1:0] fall_q;
`endif

  // Owner of the timer is masked so it cannot re-grant itself on expiry.
  always_comb begin
    req   = (bus.sw_in ^ out_q) & ~grant_q;
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 0; k < NSW; k++) begin
      idx = PW'((int'(ptr) + k) % NSW);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  // Count saturates at all-ones = HOLD-1, which is the expiry point.
  always_comb begin
    expire  = (state == HOLD) && (cnt == {CW{1'b1}});
    state_n = state;
    grant_n = grant_q;
    out_n   = out_q;
    cnt_n   = cnt;
    ptr_n   = ptr;
    unique case (state)
      IDLE: begin
      end
      HOLD: begin
        cnt_n = cnt + 1'b1;
        if (expire) begin
          state_n = IDLE;
          grant_n = '0;
        end
      end
      default: begin
      end
    endcase
    if ((state == IDLE || expire) && found) begin
      state_n      = HOLD;
      grant_n      = '0;
      grant_n[win] = 1'b1;
      out_n[win]   = ~out_q[win];
      cnt_n        = '0;
      ptr_n        = PW'((int'(win) + 1) % NSW);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      grant_q <= '0;
      out_q   <= '0;
      out_d   <= '0;
      rise_q  <= '0;
      cnt     <= '0;
      ptr     <= '0;
    end else begin
      state   <= state_n;
      grant_q <= grant_n;
      out_q   <= out_n;
      out_d   <= out_q;
      rise_q  <= out_q & ~out_d;
      cnt     <= cnt_n;
      ptr     <= ptr_n;
    end
  end

`ifdef SHARED_DEBOUNCE_FALL_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) fall_q <= '0;
    else     fall_q <= ~out_q & out_d;
  end
  assign bus.sw_fall = fall_q;
`endif

  assign bus.sw_out  = out_q;
  assign bus.sw_rise = rise_q;
  assign bus.grant   = grant_q;
  assign bus.busy    = |grant_q;
endmodule

// File: tb/tb_shared_debounce_ctrl.sv
// Bench for shared_debounce_ctrl: per-cycle scoreboard from a behavioural
// model plus directed timing checks (NSW=4, TBITS=4, HOLD=8).
module tb_shared_debounce_ctrl;
  localparam int NSW   = 4;
  localparam int TBITS = 4;
  localparam int HOLD  = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  shared_debounce_ctrl_if #(.NSW(NSW)) bus ();

  shared_debounce_ctrl #(
    .NSW  (NSW),
    .TBITS(TBITS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_chk = 0;
  int n_bad = 0;
  int cyc   = 0;
  int t0    = 0;

  logic [NSW-1:0] m_out, m_prev, m_rise;
  int m_gi, m_cnt, m_ptr;
  logic [12:0] exq[$];

  int rise_cnt[NSW];
  int gcyc[NSW];
  int first_up[NSW];

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic clr();
    for (int i = 0; i < NSW; i++) begin
      rise_cnt[i] = 0;
      gcyc[i]     = 0;
      first_up[i] = -1;
    end
    t0 = cyc;
  endtask

  // Advance model and DUT by one clock, then compare.
  task automatic step();
    logic [NSW-1:0] r_n, gv;
    logic [12:0] got, e;
    logic ex, free, hit;
    int held, i;
    if (rst) begin
      m_out  = '0;
      m_prev = '0;
      m_rise = '0;
      m_gi   = -1;
      m_cnt  = 0;
      m_ptr  = 0;
    end else begin
      r_n    = m_out & ~m_prev;
      m_prev = m_out;
      ex     = (m_gi >= 0) && (m_cnt == HOLD - 1);
      free   = (m_gi < 0) || ex;
      held   = m_gi;
      if (m_gi >= 0) m_cnt++;
      if (ex) m_gi = -1;
      hit = 1'b0;
      if (free) begin
        for (int k = 0; k < NSW; k++) begin
          i = (m_ptr + k) % NSW;
          if (!hit && i != held &&
              bus.sw_in[i] != m_out[i]) begin
            hit      = 1'b1;
            m_gi     = i;
            m_out[i] = ~m_out[i];
            m_cnt    = 0;
            m_ptr    = (i + 1) % NSW;
          end
        end
      end
      m_rise = r_n;
    end
    gv = (m_gi >= 0) ? NSW'(1 << m_gi) : '0;
    exq.push_back({m_out, m_rise, gv, (m_gi >= 0)});
    @(posedge clk);
    #1;
    cyc++;
    got = {bus.sw_out, bus.sw_rise, bus.grant, bus.busy};
    e   = exq.pop_front();
    chk("cycle", 32'(got), 32'(e));
    for (int j = 0; j < NSW; j++) begin
      if (bus.sw_rise[j]) rise_cnt[j]++;
      if (bus.grant[j]) gcyc[j]++;
      if (bus.sw_out[j] && first_up[j] < 0)
        first_up[j] = cyc - t0;
    end
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    run(2);
    rst = 1'b0;
    clr();
  endtask

  initial begin
    bus.sw_in = '0;
    // idle after reset
    do_reset();
    chk("rst_out", 32'(bus.sw_out), 0);
    chk("rst_grant", 32'(bus.grant), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    run(20);
    chk("idle_rise", rise_cnt[0] + rise_cnt[1] +
        rise_cnt[2] + rise_cnt[3], 0);
    chk("idle_out", 32'(bus.sw_out), 0);

    // bouncy press on ch1
    clr();
    bus.sw_in[1] = 1'b1; step();
    chk("lat_ch1", 32'(bus.sw_out[1]), 1);
    chk("gnt_ch1", 32'(bus.grant), 32'h2);
    bus.sw_in[1] = 1'b0; step();
    bus.sw_in[1] = 1'b1; step();
    bus.sw_in[1] = 1'b0; step();
    bus.sw_in[1] = 1'b1;
    run(12);
    chk("rise_ch1", rise_cnt[1], 1);
    chk("hold_ch1", gcyc[1], HOLD);
    chk("keep_ch1", 32'(bus.sw_out[1]), 1);

    // all four pressed together
    do_reset();
    bus.sw_in = 4'hF;
    clr();
    run(36);
    for (int i = 0; i < NSW; i++) begin
      chk("rr_up", first_up[i], 1 + HOLD * i);
      chk("rr_rise", rise_cnt[i], 1);
      chk("rr_hold", gcyc[i], HOLD);
    end
    chk("rr_idle", 32'(bus.busy), 0);

    // glitch on ch2 while ch0 holds
    do_reset();
    bus.sw_in = 4'h1;
    step();
    bus.sw_in[2] = 1'b1;
    run(3);
    bus.sw_in[2] = 1'b0;
    run(10);
    chk("glitch_gnt", gcyc[2], 0);
    chk("glitch_out", 32'(bus.sw_out[2]), 0);
    chk("glitch_ch0", gcyc[0], HOLD);

    // release bounce on ch3
    do_reset();
    bus.sw_in = 4'h8;
    step();
    chk("rb_gnt", 32'(bus.grant), 32'h8);
    run(4);
    bus.sw_in[3] = 1'b0;
    run(20);
    chk("rb_hold", gcyc[3], 2 * HOLD);
    chk("rb_out", 32'(bus.sw_out[3]), 0);
    chk("rb_rise", rise_cnt[3], 1);

    // reset in the middle of a hold
    do_reset();
    bus.sw_in = 4'h1;
    run(4);
    rst = 1'b1;
    #1;
    chk("arst_out", 32'(bus.sw_out), 0);
    chk("arst_gnt", 32'(bus.grant), 0);
    chk("arst_busy", 32'(bus.busy), 0);
    run(2);
    rst = 1'b0;
    clr();
    run(12);
    chk("post_rise", rise_cnt[0], 1);
    chk("post_out", 32'(bus.sw_out[0]), 1);
    chk("post_hold", gcyc[0], HOLD);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
